// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with a PIX_LAT-deep ce-qualified sync/DE pipeline and registered pin stage.
// Optional colour-bar generator when VGA_TEST_PATTERN_EN is defined (adds the test_mode input).
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4,
  parameter int SYNC_POL = 0,
  parameter int PIX_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               pix_ce,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  input  logic [COLOR_W-1:0] in_r,
  input  logic [COLOR_W-1:0] in_g,
  input  logic [COLOR_W-1:0] in_b,
  output logic [9:0]         req_x,
  output logic [9:0]         req_y,
  output logic               req_valid,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [COLOR_W-1:0] out_r,
  output logic [COLOR_W-1:0] out_g,
  output logic [COLOR_W-1:0] out_b,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_timing_ctrl: PIX_LAT must be within 0..4");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE < 8) begin : g_bad_mode
    $error("vga_timing_ctrl: mode does not fit 10-bit counters");
  end

  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d         = '0;
        line_start_d = 1'b1;
        if (vc_q == V_LAST) begin
          vc_d          = '0;
          frame_start_d = 1'b1;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  logic de0, hs0, vs0;
  assign de0 = (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hs0 = (hc_q >= HS_BEG) && (hc_q < HS_END);
  assign vs0 = (vc_q >= VS_BEG) && (vc_q < VS_END);

  // Stage word carries active-high syncs so an all-zero reset means "blank, syncs inactive".
`ifdef VGA_TEST_PATTERN_EN
  localparam int SW = 13;
  logic [SW-1:0] st0;
  assign st0 = {hc_q, vs0, hs0, de0};
`else
  localparam int SW = 3;
  logic [SW-1:0] st0;
  assign st0 = {vs0, hs0, de0};
`endif

  logic [SW-1:0] st_dly;

  if (PIX_LAT == 0) begin : g_nolat
    assign st_dly = st0;
  end else begin : g_pipe
    logic [SW-1:0] pipe_q [PIX_LAT];
    logic [SW-1:0] pipe_d [PIX_LAT];

    always_comb begin
      for (int i = 0; i < PIX_LAT; i++) pipe_d[i] = pipe_q[i];
      if (pix_ce) begin
        pipe_d[0] = st0;
        for (int i = 1; i < PIX_LAT; i++) pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
        for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign st_dly = pipe_q[PIX_LAT-1];
  end

  logic de_dly, hs_dly, vs_dly;
  assign de_dly = st_dly[0];
  assign hs_dly = st_dly[1];
  assign vs_dly = st_dly[2];

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [2:0] bar_k;
  assign bar_k = 3'(st_dly[12:3] / BAR_W);
`endif

  logic               out_hsync_q, out_hsync_d, out_vsync_q, out_vsync_d, out_de_q, out_de_d;
  logic [COLOR_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

  always_comb begin
    out_hsync_d = out_hsync_q;
    out_vsync_d = out_vsync_q;
    out_de_d    = out_de_q;
    out_r_d     = out_r_q;
    out_g_d     = out_g_q;
    out_b_d     = out_b_q;
    if (pix_ce) begin
      out_de_d    = de_dly;
      out_hsync_d = hs_dly ? SYNC_ACT : ~SYNC_ACT;
      out_vsync_d = vs_dly ? SYNC_ACT : ~SYNC_ACT;
      out_r_d     = '0;
      out_g_d     = '0;
      out_b_d     = '0;
      if (de_dly) begin
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
          out_r_d = {COLOR_W{bar_k[2]}};
          out_g_d = {COLOR_W{bar_k[1]}};
          out_b_d = {COLOR_W{bar_k[0]}};
        end else begin
          out_r_d = in_r;
          out_g_d = in_g;
          out_b_d = in_b;
        end
`else
        out_r_d = in_r;
        out_g_d = in_g;
        out_b_d = in_b;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      hc_q          <= '0;
      vc_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      out_hsync_q   <= ~SYNC_ACT;
      out_vsync_q   <= ~SYNC_ACT;
      out_de_q      <= 1'b0;
      out_r_q       <= '0;
      out_g_q       <= '0;
      out_b_q       <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      out_hsync_q   <= out_hsync_d;
      out_vsync_q   <= out_vsync_d;
      out_de_q      <= out_de_d;
      out_r_q       <= out_r_d;
      out_g_q       <= out_g_d;
      out_b_q       <= out_b_d;
    end
  end

  assign req_x       = hc_q;
  assign req_y       = vc_q;
  assign req_valid   = de0;
  assign out_hsync   = out_hsync_q;
  assign out_vsync   = out_vsync_q;
  assign out_de      = out_de_q;
  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a reduced mode: u0 (active-low syncs, PIX_LAT=2) and u1 (active-high, PIX_LAT=0).
// Expected pins come from a raster model indexed by the count of pix_ce pulses since reset release.
module tb_vga_timing_ctrl;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int L0 = 2, L1 = 0;

  logic clk = 1'b0, reset_p = 1'b1, pix_ce = 1'b0, tm = 1'b0;
  logic [3:0] in0_r, in0_g, in0_b, in1_r, in1_g, in1_b;
  logic [9:0] o0_x, o0_y, o1_x, o1_y;
  logic o0_valid, o0_hs, o0_vs, o0_de, o0_fs, o0_ls;
  logic o1_valid, o1_hs, o1_vs, o1_de, o1_fs, o1_ls;
  logic [3:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b;

  int checks = 0, errors = 0;
  int cnt = 0, salt = 0;
  bit src_fff = 0;
  logic e_de [2], e_hs [2], e_vs [2];
  logic [11:0] e_rgb [2];
  logic e_ls, e_fs, e_valid;
  int e_x, e_y;

  always #5 clk = ~clk;

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .COLOR_W(4), .SYNC_POL(0), .PIX_LAT(L0)) u0 (
    .clk(clk), .reset_p(reset_p), .pix_ce(pix_ce),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .in_r(in0_r), .in_g(in0_g), .in_b(in0_b), .req_x(o0_x), .req_y(o0_y), .req_valid(o0_valid),
    .out_hsync(o0_hs), .out_vsync(o0_vs), .out_de(o0_de), .out_r(o0_r), .out_g(o0_g), .out_b(o0_b),
    .frame_start(o0_fs), .line_start(o0_ls));

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VS), .V_BP(VBP), .COLOR_W(4), .SYNC_POL(1), .PIX_LAT(L1)) u1 (
    .clk(clk), .reset_p(reset_p), .pix_ce(pix_ce),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(tm),
`endif
    .in_r(in1_r), .in_g(in1_g), .in_b(in1_b), .req_x(o1_x), .req_y(o1_y), .req_valid(o1_valid),
    .out_hsync(o1_hs), .out_vsync(o1_vs), .out_de(o1_de), .out_r(o1_r), .out_g(o1_g), .out_b(o1_b),
    .frame_start(o1_fs), .line_start(o1_ls));

  // Pixel source: colour for raster position q (pulse count), independent of the DUT.
  function automatic logic [11:0] src_pix(int q);
    int x, y;
    if (q < 0) return 12'h5A5;
    if (src_fff) return 12'hFFF;
    x = q % HT;
    y = (q / HT) % VT;
    return {4'(x), 4'(y), 4'(x + y + salt)};
  endfunction

  function automatic logic [11:0] bars(int x);
    logic [2:0] k;
    k = 3'(x / (HA / 8));
    return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
  endfunction

  task automatic model_reset();
    cnt = 0; e_x = 0; e_y = 0; e_valid = 1'b1; e_ls = 1'b0; e_fs = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_de[i] = 1'b0; e_rgb[i] = 12'h000;
      e_hs[i] = (i == 0); e_vs[i] = (i == 0);
    end
  endtask

  task automatic model_pulse();
    int lat, q, x, y;
    logic pol;
    cnt++;
    e_x = cnt % HT; e_y = (cnt / HT) % VT;
    e_valid = (e_x < HA) && (e_y < VA);
    e_ls = (cnt % HT) == 0;
    e_fs = (cnt % FT) == 0;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? L0 : L1;
      pol = (i == 1);
      if (cnt >= lat + 1) begin
        q = cnt - lat - 1;
        x = q % HT; y = (q / HT) % VT;
        e_de[i] = (x < HA) && (y < VA);
        e_hs[i] = (x >= HA + HFP && x < HA + HFP + HS) ? pol : !pol;
        e_vs[i] = (y >= VA + VFP && y < VA + VFP + VS) ? pol : !pol;
        e_rgb[i] = !e_de[i] ? 12'h000 : (tm ? bars(x) : src_pix(q));
      end
    end
  endtask

  task automatic tick(input bit ce);
    {in0_r, in0_g, in0_b} = src_pix(cnt - L0);
    {in1_r, in1_g, in1_b} = src_pix(cnt - L1);
    pix_ce = ce;
    @(posedge clk);
    if (ce) model_pulse();
    else begin e_ls = 1'b0; e_fs = 1'b0; end
    @(negedge clk);
    pix_ce = 1'b0;
  endtask

  task automatic pix();
    repeat ($urandom_range(0, 2)) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_p = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 9;
    if (o0_hs !== 1'b1 || o0_vs !== 1'b1) begin errors++; $display("FAIL reset_sync0 got %b%b want 11", o0_hs, o0_vs); end
    if (o1_hs !== 1'b0 || o1_vs !== 1'b0) begin errors++; $display("FAIL reset_sync1 got %b%b want 00", o1_hs, o1_vs); end
    if (o0_de !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", o0_de); end
    if ({o0_r, o0_g, o0_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {o0_r, o0_g, o0_b}); end
    if ({o0_fs, o0_ls} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {o0_fs, o0_ls}); end
    if (o0_x !== 10'd0 || o0_y !== 10'd0) begin errors++; $display("FAIL reset_req got %0d,%0d want 0,0", o0_x, o0_y); end
    if (o0_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", o0_valid); end
    model_reset();
    reset_p = 1'b0;
    tick(1'b0); tick(1'b0);
    if ({o0_fs, o1_fs} !== 2'b00) begin errors++; $display("FAIL release_fs got %b want 00", {o0_fs, o1_fs}); end
    if (o0_x !== 10'd0) begin errors++; $display("FAIL hold_no_ce got %0d want 0", o0_x); end
  endtask

  task automatic test_timing();
    int n_de = 0, n_hs = 0, n_vs = 0, n_hedge = 0, n_ls = 0, n_fs = 0;
    logic prev_hs = 1'b1;
    do_reset();
    src_fff = 0;
    for (int k = 1; k <= L0 + 2 * FT; k++) begin
      pix();
      checks += 5;
      if (o0_x !== 10'(e_x) || o0_y !== 10'(e_y) || o0_valid !== e_valid) begin
        errors++; $display("FAIL req k=%0d got %0d,%0d,%b want %0d,%0d,%b", k, o0_x, o0_y, o0_valid, e_x, e_y, e_valid);
      end
      if ({o0_de, o0_hs, o0_vs} !== {e_de[0], e_hs[0], e_vs[0]}) begin
        errors++; $display("FAIL sync0 k=%0d got %b want %b", k, {o0_de, o0_hs, o0_vs}, {e_de[0], e_hs[0], e_vs[0]});
      end
      if ({o1_de, o1_hs, o1_vs} !== {e_de[1], e_hs[1], e_vs[1]}) begin
        errors++; $display("FAIL sync1 k=%0d got %b want %b", k, {o1_de, o1_hs, o1_vs}, {e_de[1], e_hs[1], e_vs[1]});
      end
      if ({o0_ls, o0_fs} !== {e_ls, e_fs}) begin
        errors++; $display("FAIL pulses k=%0d got %b want %b", k, {o0_ls, o0_fs}, {e_ls, e_fs});
      end
      if (k <= 2 * FT) begin n_ls += o0_ls; n_fs += o0_fs; end
      if (k >= L0 + 1) begin
        n_de += o0_de; n_hs += !o0_hs; n_vs += !o0_vs;
        if (prev_hs && !o0_hs) n_hedge++;
        prev_hs = o0_hs;
      end
      tick(1'b0);
      if ({o0_ls, o0_fs} !== 2'b00) begin
        errors++; $display("FAIL pulse_width k=%0d got %b want 00", k, {o0_ls, o0_fs});
      end
    end
    checks += 6;
    if (n_de !== 2 * HA * VA) begin errors++; $display("FAIL de_count got %0d want %0d", n_de, 2 * HA * VA); end
    if (n_hs !== 2 * VT * HS) begin errors++; $display("FAIL hs_count got %0d want %0d", n_hs, 2 * VT * HS); end
    if (n_vs !== 2 * VS * HT) begin errors++; $display("FAIL vs_count got %0d want %0d", n_vs, 2 * VS * HT); end
    if (n_hedge !== 2 * VT) begin errors++; $display("FAIL hs_periods got %0d want %0d", n_hedge, 2 * VT); end
    if (n_ls !== 2 * VT) begin errors++; $display("FAIL line_starts got %0d want %0d", n_ls, 2 * VT); end
    if (n_fs !== 2) begin errors++; $display("FAIL frame_starts got %0d want 2", n_fs); end
  endtask

  task automatic test_pixel_data();
    salt = $urandom_range(0, 15);
    src_fff = 0;
    do_reset();
    for (int k = 1; k <= L0 + FT; k++) begin
      pix();
      checks += 2;
      if ({o0_r, o0_g, o0_b} !== e_rgb[0]) begin errors++; $display("FAIL pix0 k=%0d got %h want %h", k, {o0_r, o0_g, o0_b}, e_rgb[0]); end
      if ({o1_r, o1_g, o1_b} !== e_rgb[1]) begin errors++; $display("FAIL pix1 k=%0d got %h want %h", k, {o1_r, o1_g, o1_b}, e_rgb[1]); end
    end
  endtask

  task automatic test_blank();
    src_fff = 1;
    do_reset();
    for (int k = 1; k <= L0 + FT; k++) begin
      pix();
      checks += 2;
      if ({o0_de, o0_r, o0_g, o0_b} !== {e_de[0], e_rgb[0]}) begin
        errors++; $display("FAIL blank k=%0d got %b/%h want %b/%h", k, o0_de, {o0_r, o0_g, o0_b}, e_de[0], e_rgb[0]);
      end
      tick(1'b0);
      if ({o0_de, o0_hs, o0_r, o0_g, o0_b} !== {e_de[0], e_hs[0], e_rgb[0]}) begin
        errors++; $display("FAIL hold k=%0d got %b%b/%h want %b%b/%h", k, o0_de, o0_hs, {o0_r, o0_g, o0_b},
                           e_de[0], e_hs[0], e_rgb[0]);
      end
    end
    src_fff = 0;
  endtask

  task automatic test_reset_midline();
    int first0 = -1, first1 = -1;
    do_reset();
    while (cnt < 3 * HT + 10) pix();
    #1 reset_p = 1'b1;
    #1;
    checks += 3;
    if ({o0_hs, o0_vs, o0_de, o0_r, o0_g, o0_b} !== {3'b110, 12'h000}) begin
      errors++; $display("FAIL async_rst0 got %b%b%b/%h want 110/000", o0_hs, o0_vs, o0_de, {o0_r, o0_g, o0_b});
    end
    if ({o1_hs, o1_vs, o1_de} !== 3'b000) begin errors++; $display("FAIL async_rst1 got %b want 000", {o1_hs, o1_vs, o1_de}); end
    if (o0_x !== 10'd0 || o0_y !== 10'd0) begin errors++; $display("FAIL async_rst_req got %0d,%0d want 0,0", o0_x, o0_y); end
    model_reset();
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    for (int n = 0; n < 200 && (first0 < 0 || first1 < 0); n++) begin
      pix();
      if (first0 < 0 && o0_hs === 1'b0) first0 = cnt;
      if (first1 < 0 && o1_hs === 1'b1) first1 = cnt;
    end
    checks += 2;
    if (first0 !== HA + HFP + L0 + 1) begin errors++; $display("FAIL first_hs0 got %0d want %0d", first0, HA + HFP + L0 + 1); end
    if (first1 !== HA + HFP + L1 + 1) begin errors++; $display("FAIL first_hs1 got %0d want %0d", first1, HA + HFP + L1 + 1); end
  endtask

  task automatic test_sync_pol();
    do_reset();
    for (int k = 1; k <= FT + 2; k++) begin
      pix();
      checks += 1;
      if ({o1_hs, o1_vs} !== {e_hs[1], e_vs[1]}) begin
        errors++; $display("FAIL pol1 k=%0d got %b want %b", k, {o1_hs, o1_vs}, {e_hs[1], e_vs[1]});
      end
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int px;
    src_fff = 0;
    do_reset();
    tm = 1'b1;
    for (int k = 1; k <= L0 + FT + 2 * HT; k++) begin
      if (k == L0 + FT + 10) tm = 1'b0;
      pix();
      px = (cnt - L0 - 1) % HT;
      checks += 2;
      if ({o0_r, o0_g, o0_b} !== e_rgb[0]) begin errors++; $display("FAIL tp0 k=%0d got %h want %h", k, {o0_r, o0_g, o0_b}, e_rgb[0]); end
      if ({o1_r, o1_g, o1_b} !== e_rgb[1]) begin errors++; $display("FAIL tp1 k=%0d got %h want %h", k, {o1_r, o1_g, o1_b}, e_rgb[1]); end
      if (tm && o0_de === 1'b1 && (px == 0 || px == HA / 8 || px == HA - 1)) begin
        checks++;
        if ({o0_r, o0_g, o0_b} !== (px == 0 ? 12'h000 : (px == HA / 8 ? 12'h00F : 12'hFFF))) begin
          errors++; $display("FAIL tp_bar x=%0d got %h", px, {o0_r, o0_g, o0_b});
        end
      end
    end
    tm = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_timing();
    test_pixel_data();
    test_blank();
    test_reset_midline();
    test_sync_pol();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
